// File: rtl/ins_cache_pkg.sv
// ins_cache_pkg -- shared types and helpers for the single-line RV32I
// instruction cache.
//   state_t    : fill controller states (READY, FILL)
//   offw_of    : offset width for a given block size
//   tag_of     : upper address bits above the word offset
//   offset_of  : word offset inside the cached block
package ins_cache_pkg;

  typedef enum logic {
    READY = 1'b0,
    FILL  = 1'b1
  } state_t;

  function automatic int offw_of(input int cached_ins);
    return $clog2(cached_ins);
  endfunction

  // Helpers work on a wide container; callers cast down to their widths.
  function automatic logic [63:0] tag_of(input logic [63:0] addr, input int offw);
    return addr >> offw;
  endfunction

  function automatic logic [63:0] offset_of(input logic [63:0] addr, input int offw);
    return addr & ((64'd1 << offw) - 64'd1);
  endfunction

endpackage

// File: rtl/ins_cache_r32i_if.sv
// ins_cache_r32i_if -- fetch/memory side signals of the instruction cache.
//   ProgAddr         : word address requested by fetch
//   InsReadInp       : combinational read data from instruction memory
//   InsCacheStall    : fetch must hold while high
//   InsCacheReadAddr : word address presented to instruction memory
//   OutputIns        : instruction at ProgAddr when not stalled
// Modports: slave = cache side, master = fetch/memory side.
interface ins_cache_r32i_if #(
  parameter int dataW = 32
);
  logic [dataW-1:0] ProgAddr;
  logic [dataW-1:0] InsReadInp;
  logic             InsCacheStall;
  logic [dataW-1:0] InsCacheReadAddr;
  logic [dataW-1:0] OutputIns;

  modport slave (
    input  ProgAddr,
    input  InsReadInp,
    output InsCacheStall,
    output InsCacheReadAddr,
    output OutputIns
  );

  modport master (
    output ProgAddr,
    output InsReadInp,
    input  InsCacheStall,
    input  InsCacheReadAddr,
    input  OutputIns
  );
endinterface

// File: rtl/ins_cache_fill_ctrl.sv
// ins_cache_fill_ctrl -- refill sequencer for the single-line cache.
//   clock, reset : clock and synchronous active-high reset
//   hit          : current request hits the line
//   tag          : tag of the current request
//   state        : READY / FILL
//   line_we      : write strobe for the line array
//   line_widx    : word index written this cycle
//   read_addr    : address presented to instruction memory
//   fill_start   : READY->FILL transition happens at the next edge
//   fill_done    : last word of the block is written at the next edge
//   fill_tag     : tag of the block being filled
module ins_cache_fill_ctrl
  import ins_cache_pkg::*;
#(
  parameter int dataW     = 32,
  parameter int CachedIns = 8,
  localparam int OFFW     = offw_of(CachedIns),
  localparam int TAGW     = dataW - OFFW
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             hit,
  input  logic [TAGW-1:0]  tag,
  output state_t           state,
  output logic             line_we,
  output logic [OFFW-1:0]  line_widx,
  output logic [dataW-1:0] read_addr,
  output logic             fill_start,
  output logic             fill_done,
  output logic [TAGW-1:0]  fill_tag
);

  state_t          state_reg, state_next;
  logic [OFFW-1:0] fill_cnt_reg, fill_cnt_next;
  logic [TAGW-1:0] fill_tag_reg, fill_tag_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= READY;
      fill_cnt_reg <= '0;
      fill_tag_reg <= '0;
    end else begin
      state_reg    <= state_next;
      fill_cnt_reg <= fill_cnt_next;
      fill_tag_reg <= fill_tag_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    fill_cnt_next = fill_cnt_reg;
    fill_tag_next = fill_tag_reg;
    line_we       = 1'b0;
    line_widx     = fill_cnt_reg;
    read_addr     = {tag, {OFFW{1'b0}}};
    fill_start    = 1'b0;
    fill_done     = 1'b0;
    case (state_reg)
      READY: begin
        if (!hit) begin
          // Word 0 is already on the memory bus, so capture it on this edge.
          fill_start    = 1'b1;
          line_we       = 1'b1;
          line_widx     = '0;
          fill_cnt_next = OFFW'(1);
          fill_tag_next = tag;
          state_next    = FILL;
        end
      end
      FILL: begin
        // Tag is frozen: a ProgAddr change mid-fill does not redirect it.
        read_addr     = {fill_tag_reg, fill_cnt_reg};
        line_we       = 1'b1;
        fill_cnt_next = fill_cnt_reg + OFFW'(1);
        if (fill_cnt_reg == {OFFW{1'b1}}) begin
          fill_done  = 1'b1;
          state_next = READY;
        end
      end
      default: state_next = READY;
    endcase
  end

  assign state    = state_reg;
  assign fill_tag = fill_tag_reg;

endmodule

// File: rtl/ins_cache_r32i.sv
// ins_cache_r32i -- single-line, direct-mapped RV32I instruction cache.
//   clock, reset : clock and synchronous active-high reset
//   bus          : ins_cache_r32i_if.slave (fetch request, memory read,
//                  stall, memory address, instruction out)
//   HitCount, MissCount : saturating performance counters, present only
//                  when INS_CACHE_PERF_CNT_EN is defined
// Hits are served combinationally; a miss refills the whole block, one
// word per cycle, taking exactly CachedIns edges.
module ins_cache_r32i
  import ins_cache_pkg::*;
#(
  parameter int dataW     = 32,
  parameter int CachedIns = 8
) (
  input  logic             clock,
  input  logic             reset,
`ifdef INS_CACHE_PERF_CNT_EN
  output logic [31:0]      HitCount,
  output logic [31:0]      MissCount,
`endif
  ins_cache_r32i_if.slave  bus
);

  localparam int OFFW = offw_of(CachedIns);
  localparam int TAGW = dataW - OFFW;

  logic [dataW-1:0] line_mem [CachedIns];
  logic [TAGW-1:0]  line_tag_reg;
  logic             valid_reg;

  logic [TAGW-1:0]  tag;
  logic [OFFW-1:0]  offset;
  logic             hit;
  state_t           state;
  logic             line_we;
  logic [OFFW-1:0]  line_widx;
  logic             fill_start;
  logic             fill_done;
  logic [TAGW-1:0]  fill_tag;

  assign tag    = TAGW'(tag_of(64'(bus.ProgAddr), OFFW));
  assign offset = OFFW'(offset_of(64'(bus.ProgAddr), OFFW));
  assign hit    = valid_reg && (line_tag_reg == tag) && (state == READY);

  ins_cache_fill_ctrl #(
    .dataW     (dataW),
    .CachedIns (CachedIns)
  ) u_fill_ctrl (
    .clock      (clock),
    .reset      (reset),
    .hit        (hit),
    .tag        (tag),
    .state      (state),
    .line_we    (line_we),
    .line_widx  (line_widx),
    .read_addr  (bus.InsCacheReadAddr),
    .fill_start (fill_start),
    .fill_done  (fill_done),
    .fill_tag   (fill_tag)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_reg    <= 1'b0;
      line_tag_reg <= '0;
    end else if (fill_start) begin
      valid_reg <= 1'b0;
    end else if (fill_done) begin
      valid_reg    <= 1'b1;
      line_tag_reg <= fill_tag;
    end
  end

  // Line contents are deliberately not reset; valid_reg guards them.
  always_ff @(posedge clock) begin
    if (line_we) begin
      line_mem[line_widx] <= bus.InsReadInp;
    end
  end

  assign bus.InsCacheStall = !hit;
  assign bus.OutputIns     = hit ? line_mem[offset] : '0;

`ifdef INS_CACHE_PERF_CNT_EN
  logic [31:0] hit_count_reg;
  logic [31:0] miss_count_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      hit_count_reg  <= '0;
      miss_count_reg <= '0;
    end else begin
      if (hit && hit_count_reg != '1) begin
        hit_count_reg <= hit_count_reg + 32'd1;
      end
      if (fill_start && miss_count_reg != '1) begin
        miss_count_reg <= miss_count_reg + 32'd1;
      end
    end
  end

  assign HitCount  = hit_count_reg;
  assign MissCount = miss_count_reg;
`endif

endmodule

// File: tb/tb_ins_cache_r32i.sv
// tb_ins_cache_r32i -- directed bench for ins_cache_r32i.
// Table of per-cycle vectors for cold fill, hits and block replacement,
// then hand-written sequences for mid-fill address change, mid-fill
// reset and top-of-memory wrap. Perf counters are checked when
// INS_CACHE_PERF_CNT_EN is defined.
module tb_ins_cache_r32i;

  logic clock;
  logic reset;
  logic mem_const;
  int   checks;
  int   passes;

  ins_cache_r32i_if #(.dataW(32)) bus ();

`ifdef INS_CACHE_PERF_CNT_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  ins_cache_r32i #(
    .dataW     (32),
    .CachedIns (8)
  ) dut (
    .clock     (clock),
    .reset     (reset),
`ifdef INS_CACHE_PERF_CNT_EN
    .HitCount  (hit_count),
    .MissCount (miss_count),
`endif
    .bus       (bus.slave)
  );

  // Memory model: either returns the address itself or a constant 69.
  assign bus.InsReadInp = mem_const ? 32'd69 : bus.InsCacheReadAddr;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic        mc;
    logic        stall;
    logic [31:0] rd_addr;
    logic [31:0] ins;
  } vec_t;

  vec_t vecs [23];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1 reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Hold ProgAddr for one cycle, check stall/readaddr, then advance.
  task automatic fill_cycle(input string name, input logic [31:0] addr, input logic [31:0] rd);
    bus.ProgAddr = addr;
    @(negedge clock);
    check({name, " stall"}, {31'd0, bus.InsCacheStall}, 32'd1);
    check({name, " rdaddr"}, bus.InsCacheReadAddr, rd);
    $display("fill %s addr=%0h rdaddr=%0h", name, addr, bus.InsCacheReadAddr);
    step();
  endtask

  task automatic hit_cycle(input string name, input logic [31:0] addr, input logic [31:0] ins);
    bus.ProgAddr = addr;
    @(negedge clock);
    check({name, " stall"}, {31'd0, bus.InsCacheStall}, 32'd0);
    check({name, " ins"}, bus.OutputIns, ins);
    $display("hit %s addr=%0h ins=%0h", name, addr, bus.OutputIns);
    step();
  endtask

  initial begin
    checks        = 0;
    passes        = 0;
    reset         = 1'b1;
    mem_const     = 1'b0;
    bus.ProgAddr  = '0;

    // Scenario 1: cold fill of block 0 (memory returns address).
    for (int i = 0; i < 8; i++)
      vecs[i] = '{32'd0, 1'b0, 1'b1, 32'(i), 32'd0};
    vecs[8]  = '{32'd0, 1'b0, 1'b0, 32'd0, 32'd0};
    // Scenario 2: hits inside block 0.
    vecs[9]  = '{32'd1, 1'b0, 1'b0, 32'd0, 32'd1};
    vecs[10] = '{32'd6, 1'b0, 1'b0, 32'd0, 32'd6};
    vecs[11] = '{32'd4, 1'b0, 1'b0, 32'd0, 32'd4};
    // Scenario 3: replace with block 32 (memory returns 69).
    for (int i = 0; i < 8; i++)
      vecs[12 + i] = '{32'd32, 1'b1, 1'b1, 32'(32 + i), 32'd0};
    vecs[20] = '{32'd32, 1'b1, 1'b0, 32'd32, 32'd69};
    vecs[21] = '{32'd37, 1'b1, 1'b0, 32'd32, 32'd69};
    vecs[22] = '{32'd1,  1'b1, 1'b1, 32'd0,  32'd0};

    step();
    step();
    reset = 1'b0;

    for (int i = 0; i < 23; i++) begin
      bus.ProgAddr = vecs[i].addr;
      mem_const    = vecs[i].mc;
      @(negedge clock);
      check($sformatf("vec%0d stall", i), {31'd0, bus.InsCacheStall}, {31'd0, vecs[i].stall});
      check($sformatf("vec%0d rdaddr", i), bus.InsCacheReadAddr, vecs[i].rd_addr);
      check($sformatf("vec%0d ins", i), bus.OutputIns, vecs[i].ins);
      $display("vec%0d addr=%0h stall=%0b rdaddr=%0h ins=%0h", i, vecs[i].addr,
               bus.InsCacheStall, bus.InsCacheReadAddr, bus.OutputIns);
`ifdef INS_CACHE_PERF_CNT_EN
      if (i == 22) begin
        check("miss_count", miss_count, 32'd2);
        check("hit_count", hit_count, 32'd6);
      end
`endif
      step();
    end

    // Scenario 4: ProgAddr moves from block 8 to block 16 mid-fill.
    mem_const = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) fill_cycle("s4a", 32'd8, 32'(8 + i));
    for (int i = 3; i < 8; i++) fill_cycle("s4a", 32'd16, 32'(8 + i));
    for (int i = 0; i < 8; i++) fill_cycle("s4b", 32'd16, 32'(16 + i));
    hit_cycle("s4 hit16", 32'd16, 32'd16);
    hit_cycle("s4 hit21", 32'd21, 32'd21);

    // Scenario 5: reset during fill cycle 4 of block 40.
    do_reset();
    for (int i = 0; i < 4; i++) fill_cycle("s5a", 32'd42, 32'(40 + i));
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) fill_cycle("s5b", 32'd42, 32'(40 + i));
    hit_cycle("s5 hit42", 32'd42, 32'd42);

    // Top-of-memory block: no carry out of the tag.
    for (int i = 0; i < 8; i++) fill_cycle("wrap", 32'hFFFF_FFFF, 32'hFFFF_FFF8 + 32'(i));
    hit_cycle("wrap hit", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    hit_cycle("wrap hit8", 32'hFFFF_FFF8, 32'hFFFF_FFF8);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
